// File: rtl/decode_queue.sv
// decode_queue: RV32IM decode stage feeding a DEPTH-entry elastic queue.
// Instructions are decoded at push time and stored already decoded, so the
// head outputs come straight from storage. Popping an M-extension op holds
// off the next issue for MULDIV_LAT-1 cycles. A flush clears the queue
// synchronously.
//
// Optional feature: define DECODE_BYPASS_EN to let an instruction arriving
// at an empty, idle queue with a ready consumer go out in the same cycle.
//
// Ports:
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_flush            synchronous queue clear (redirect)
//   i_in_valid/o_in_ready, i_in_inst, i_in_pc     fetch side
//   o_out_valid/i_out_ready                       issue side
//   o_out_ctrl, o_out_pc, o_out_imm, o_out_rs1, o_out_rs2, o_out_rd,
//   o_out_illegal      decoded head entry

package decode_queue_pkg;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BR     = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // ALU op codes line up with arithmetic funct3 except sra (2) and sub (3).
  typedef enum logic [2:0] {
    ALU_ADD = 3'd0, ALU_SLL = 3'd1, ALU_SRA = 3'd2, ALU_SUB = 3'd3,
    ALU_XOR = 3'd4, ALU_SRL = 3'd5, ALU_OR  = 3'd6, ALU_AND = 3'd7
  } alu_op_t;

  // Compare op codes are the branch funct3 values.
  typedef enum logic [2:0] {
    CMP_BEQ = 3'd0, CMP_BNE = 3'd1, CMP_BLT = 3'd4,
    CMP_BGE = 3'd5, CMP_BLTU = 3'd6, CMP_BGEU = 3'd7
  } cmp_op_t;

  typedef enum logic       {A1_RS1 = 1'b0, A1_PC = 1'b1} alumux1_t;
  typedef enum logic [2:0] {
    A2_I_IMM = 3'd0, A2_U_IMM = 3'd1, A2_B_IMM = 3'd2,
    A2_S_IMM = 3'd3, A2_J_IMM = 3'd4, A2_RS2 = 3'd5
  } alumux2_t;
  typedef enum logic       {CM_RS2 = 1'b0, CM_I_IMM = 1'b1} cmpmux_t;
  typedef enum logic [3:0] {
    RFM_ALU_OUT = 4'd0, RFM_BR_EN = 4'd1, RFM_U_IMM = 4'd2, RFM_LW = 4'd3,
    RFM_PC_PLUS4 = 4'd4, RFM_LB = 4'd5, RFM_LBU = 4'd6, RFM_LH = 4'd7,
    RFM_LHU = 4'd8
  } regfilemux_t;
  typedef enum logic       {MM_PC = 1'b0, MM_ALU_OUT = 1'b1} marmux_t;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    alu_op_t     aluop;
    cmp_op_t     cmpop;
    alumux1_t    alumux1_sel;
    alumux2_t    alumux2_sel;
    cmpmux_t     cmpmux_sel;
    regfilemux_t regfilemux_sel;
    marmux_t     marmux_sel;
    logic        load_regfile;
    logic        dmem_read;
    logic        dmem_write;
    logic [3:0]  dmem_rmask;
    logic [3:0]  dmem_wmask;
    logic        muldiv;      // M-extension op; funct3 selects mul/div flavour
  } rv32i_control_word;
endpackage

module decode_queue
  import decode_queue_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int MULDIV_LAT = 4,
  parameter int XLEN       = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_flush,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [XLEN-1:0]   i_in_inst,
  input  logic [XLEN-1:0]   i_in_pc,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output rv32i_control_word o_out_ctrl,
  output logic [XLEN-1:0]   o_out_pc,
  output logic [XLEN-1:0]   o_out_imm,
  output logic [4:0]        o_out_rs1,
  output logic [4:0]        o_out_rs2,
  output logic [4:0]        o_out_rd,
  output logic              o_out_illegal
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int BW = (MULDIV_LAT > 1) ? $clog2(MULDIV_LAT) : 1;

  typedef struct packed {
    rv32i_control_word ctrl;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   imm;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
    logic              illegal;
  } entry_t;

  entry_t          r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic [BW-1:0]   r_busy;

  entry_t          w_dec, w_head;
  logic [6:0]      w_opc, w_f7;
  logic [2:0]      w_f3;
  logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  logic            w_full, w_empty, w_bypass, w_push, w_pop, w_issue_mext;

  assign w_opc = i_in_inst[6:0];
  assign w_f3  = i_in_inst[14:12];
  assign w_f7  = i_in_inst[31:25];

  assign w_imm_i = {{(XLEN-11){i_in_inst[31]}}, i_in_inst[30:20]};
  assign w_imm_s = {{(XLEN-11){i_in_inst[31]}}, i_in_inst[30:25], i_in_inst[11:7]};
  assign w_imm_b = {{(XLEN-12){i_in_inst[31]}}, i_in_inst[7], i_in_inst[30:25],
                    i_in_inst[11:8], 1'b0};
  assign w_imm_u = {{(XLEN-31){i_in_inst[31]}}, i_in_inst[30:12], 12'b0};
  assign w_imm_j = {{(XLEN-20){i_in_inst[31]}}, i_in_inst[19:12], i_in_inst[20],
                    i_in_inst[30:21], 1'b0};

  // Decode of the incoming word
  always_comb begin
    w_dec             = '0;
    w_dec.pc          = i_in_pc;
    w_dec.rs1         = i_in_inst[19:15];
    w_dec.rs2         = i_in_inst[24:20];
    w_dec.ctrl.opcode = w_opc;
    w_dec.ctrl.funct3 = w_f3;
    case (w_opc)
      OP_LUI: begin
        w_dec.imm                 = w_imm_u;
        w_dec.ctrl.load_regfile   = 1'b1;
        w_dec.ctrl.regfilemux_sel = RFM_U_IMM;
      end
      OP_AUIPC: begin
        w_dec.imm                 = w_imm_u;
        w_dec.ctrl.alumux1_sel    = A1_PC;
        w_dec.ctrl.alumux2_sel    = A2_U_IMM;
        w_dec.ctrl.load_regfile   = 1'b1;
      end
      OP_JAL: begin
        w_dec.imm                 = w_imm_j;
        w_dec.ctrl.alumux1_sel    = A1_PC;
        w_dec.ctrl.alumux2_sel    = A2_J_IMM;
        w_dec.ctrl.load_regfile   = 1'b1;
        w_dec.ctrl.regfilemux_sel = RFM_PC_PLUS4;
      end
      OP_JALR: begin
        w_dec.imm                 = w_imm_i;
        w_dec.ctrl.load_regfile   = 1'b1;
        w_dec.ctrl.regfilemux_sel = RFM_PC_PLUS4;
      end
      OP_BR: begin
        w_dec.imm                 = w_imm_b;
        w_dec.ctrl.alumux1_sel    = A1_PC;
        w_dec.ctrl.alumux2_sel    = A2_B_IMM;
        w_dec.ctrl.cmpop          = cmp_op_t'(w_f3);
      end
      OP_LOAD: begin
        w_dec.imm                 = w_imm_i;
        w_dec.ctrl.marmux_sel     = MM_ALU_OUT;
        w_dec.ctrl.dmem_read      = 1'b1;
        w_dec.ctrl.load_regfile   = 1'b1;
        case (w_f3)
          3'b000:  begin w_dec.ctrl.regfilemux_sel = RFM_LB;  w_dec.ctrl.dmem_rmask = 4'b0001; end
          3'b001:  begin w_dec.ctrl.regfilemux_sel = RFM_LH;  w_dec.ctrl.dmem_rmask = 4'b0011; end
          3'b100:  begin w_dec.ctrl.regfilemux_sel = RFM_LBU; w_dec.ctrl.dmem_rmask = 4'b0001; end
          3'b101:  begin w_dec.ctrl.regfilemux_sel = RFM_LHU; w_dec.ctrl.dmem_rmask = 4'b0011; end
          default: begin w_dec.ctrl.regfilemux_sel = RFM_LW;  w_dec.ctrl.dmem_rmask = 4'b1111; end
        endcase
      end
      OP_STORE: begin
        w_dec.imm                 = w_imm_s;
        w_dec.ctrl.alumux2_sel    = A2_S_IMM;
        w_dec.ctrl.marmux_sel     = MM_ALU_OUT;
        w_dec.ctrl.dmem_write     = 1'b1;
        case (w_f3)
          3'b000:  w_dec.ctrl.dmem_wmask = 4'b0001;
          3'b001:  w_dec.ctrl.dmem_wmask = 4'b0011;
          default: w_dec.ctrl.dmem_wmask = 4'b1111;
        endcase
      end
      OP_IMM, OP_REG: begin
        w_dec.ctrl.load_regfile = 1'b1;
        if (w_opc == OP_IMM) begin
          w_dec.imm              = w_imm_i;
          w_dec.ctrl.cmpmux_sel  = CM_I_IMM;
        end else begin
          w_dec.ctrl.alumux2_sel = A2_RS2;
        end
        if (w_opc == OP_REG && w_f7 == 7'b0000001) begin
          w_dec.ctrl.muldiv = 1'b1;
        end else if (w_f3 == 3'b010 || w_f3 == 3'b011) begin
          w_dec.ctrl.cmpop          = (w_f3 == 3'b010) ? CMP_BLT : CMP_BLTU;
          w_dec.ctrl.regfilemux_sel = RFM_BR_EN;
        end else begin
          w_dec.ctrl.aluop = alu_op_t'(w_f3);
          if (w_f3 == 3'b101 && i_in_inst[30])
            w_dec.ctrl.aluop = ALU_SRA;
          else if (w_f3 == 3'b000 && w_opc == OP_REG && i_in_inst[30])
            w_dec.ctrl.aluop = ALU_SUB;
        end
      end
      OP_FENCE, OP_SYSTEM: ;  // legal, no architectural effect here
      default: w_dec.illegal = 1'b1;
    endcase
    w_dec.rd = w_dec.ctrl.load_regfile ? i_in_inst[11:7] : 5'd0;
  end

  assign w_full     = (r_count == CW'(DEPTH));
  assign w_empty    = (r_count == '0);
  assign o_in_ready = !w_full && !i_flush;

`ifdef DECODE_BYPASS_EN
  assign w_bypass = i_rst_n && w_empty && (r_busy == '0) && !i_flush &&
                    i_in_valid && i_out_ready;
  assign w_head   = w_bypass ? w_dec : r_mem[r_rd_ptr];
`else
  assign w_bypass = 1'b0;
  assign w_head   = r_mem[r_rd_ptr];
`endif

  assign o_out_valid  = (!w_empty && (r_busy == '0) && !i_flush) || w_bypass;
  assign w_push       = i_in_valid && o_in_ready && !w_bypass;
  assign w_pop        = o_out_valid && i_out_ready && !w_bypass;
  // A bypassed M op paces the following issue just like a queued one
  assign w_issue_mext = o_out_valid && i_out_ready && w_head.ctrl.muldiv;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_busy   <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_busy   <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_dec;
        r_wr_ptr        <= r_wr_ptr + 1'b1;   // DEPTH is a power of two
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
      if (w_issue_mext && MULDIV_LAT > 1) r_busy <= BW'(MULDIV_LAT - 1);
      else if (r_busy != '0)              r_busy <= r_busy - 1'b1;
    end
  end

  assign o_out_ctrl    = w_head.ctrl;
  assign o_out_pc      = w_head.pc;
  assign o_out_imm     = w_head.imm;
  assign o_out_rs1     = w_head.rs1;
  assign o_out_rs2     = w_head.rs2;
  assign o_out_rd      = w_head.rd;
  assign o_out_illegal = w_head.illegal;
endmodule

// File: tb/tb_decode_queue.sv
module tb_decode_queue;
  import decode_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int LAT   = 4;
  localparam int XLEN  = 32;
`ifdef DECODE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [XLEN-1:0]   in_inst, in_pc, out_pc, out_imm;
  logic [4:0]        out_rs1, out_rs2, out_rd;
  logic              out_illegal;
  rv32i_control_word out_ctrl;

  decode_queue #(.DEPTH(DEPTH), .MULDIV_LAT(LAT), .XLEN(XLEN)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush),
    .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_inst(in_inst), .i_in_pc(in_pc),
    .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_ctrl(out_ctrl),
    .o_out_pc(out_pc), .o_out_imm(out_imm), .o_out_rs1(out_rs1), .o_out_rs2(out_rs2),
    .o_out_rd(out_rd), .o_out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    rv32i_control_word ctrl;
    logic [31:0]       pc, imm;
    logic [4:0]        rs1, rs2, rd;
    logic              illegal;
  } ment_t;

  ment_t mq[$];
  int    mbusy;
  int    errors = 0;
  int    checks = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic alu_op_t arith_op(input logic [2:0] f3, input bit alt, input bit is_reg);
    case (f3)
      3'd0:    return (is_reg && alt) ? ALU_SUB : ALU_ADD;
      3'd1:    return ALU_SLL;
      3'd4:    return ALU_XOR;
      3'd5:    return alt ? ALU_SRA : ALU_SRL;
      3'd6:    return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  // Reference decode from the instruction-set rules
  function automatic ment_t mdec(input logic [31:0] w, input logic [31:0] pc);
    ment_t e;
    logic [6:0] op = w[6:0];
    logic [2:0] f3 = w[14:12];
    bit writes = 1'b0;
    e.ctrl = '0; e.pc = pc; e.imm = 32'd0; e.rs1 = w[19:15]; e.rs2 = w[24:20];
    e.illegal = 1'b0;
    e.ctrl.opcode = op; e.ctrl.funct3 = f3;
    case (op)
      7'h37: begin writes = 1; e.imm = {w[31:12], 12'h000}; e.ctrl.regfilemux_sel = RFM_U_IMM; end
      7'h17: begin writes = 1; e.imm = {w[31:12], 12'h000}; e.ctrl.alumux1_sel = A1_PC;
                   e.ctrl.alumux2_sel = A2_U_IMM; end
      7'h6F: begin writes = 1; e.imm = 32'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
                   e.ctrl.alumux1_sel = A1_PC; e.ctrl.alumux2_sel = A2_J_IMM;
                   e.ctrl.regfilemux_sel = RFM_PC_PLUS4; end
      7'h67: begin writes = 1; e.imm = 32'($signed(w[31:20])); e.ctrl.regfilemux_sel = RFM_PC_PLUS4; end
      7'h63: begin e.imm = 32'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
                   e.ctrl.alumux1_sel = A1_PC; e.ctrl.alumux2_sel = A2_B_IMM;
                   e.ctrl.cmpop = cmp_op_t'(f3); end
      7'h03: begin writes = 1; e.imm = 32'($signed(w[31:20])); e.ctrl.marmux_sel = MM_ALU_OUT;
                   e.ctrl.dmem_read = 1;
                   case (f3)
                     3'd0: begin e.ctrl.regfilemux_sel = RFM_LB;  e.ctrl.dmem_rmask = 4'h1; end
                     3'd1: begin e.ctrl.regfilemux_sel = RFM_LH;  e.ctrl.dmem_rmask = 4'h3; end
                     3'd4: begin e.ctrl.regfilemux_sel = RFM_LBU; e.ctrl.dmem_rmask = 4'h1; end
                     3'd5: begin e.ctrl.regfilemux_sel = RFM_LHU; e.ctrl.dmem_rmask = 4'h3; end
                     default: begin e.ctrl.regfilemux_sel = RFM_LW; e.ctrl.dmem_rmask = 4'hF; end
                   endcase end
      7'h23: begin e.imm = 32'($signed({w[31:25], w[11:7]})); e.ctrl.alumux2_sel = A2_S_IMM;
                   e.ctrl.marmux_sel = MM_ALU_OUT; e.ctrl.dmem_write = 1;
                   e.ctrl.dmem_wmask = (f3 == 3'd0) ? 4'h1 : (f3 == 3'd1) ? 4'h3 : 4'hF; end
      7'h13, 7'h33: begin
        writes = 1;
        if (op == 7'h13) begin e.imm = 32'($signed(w[31:20])); e.ctrl.cmpmux_sel = CM_I_IMM; end
        else e.ctrl.alumux2_sel = A2_RS2;
        if (op == 7'h33 && w[31:25] == 7'd1) e.ctrl.muldiv = 1;
        else if (f3 == 3'd2) begin e.ctrl.cmpop = CMP_BLT;  e.ctrl.regfilemux_sel = RFM_BR_EN; end
        else if (f3 == 3'd3) begin e.ctrl.cmpop = CMP_BLTU; e.ctrl.regfilemux_sel = RFM_BR_EN; end
        else e.ctrl.aluop = arith_op(f3, w[30], op == 7'h33);
      end
      7'h0F, 7'h73: ;
      default: e.illegal = 1'b1;
    endcase
    e.ctrl.load_regfile = writes;
    e.rd = writes ? w[11:7] : 5'd0;
    return e;
  endfunction

  function automatic logic [31:0] rnd_inst();
    logic [31:0] w = $urandom;
    case ($urandom_range(0, 11))
      0:  w[6:0] = 7'h37;
      1:  w[6:0] = 7'h17;
      2:  w[6:0] = 7'h6F;
      3:  w[6:0] = 7'h67;
      4:  w[6:0] = 7'h63;
      5:  w[6:0] = 7'h03;
      6:  w[6:0] = 7'h23;
      7:  w[6:0] = 7'h13;
      8, 9: begin
        w[6:0] = 7'h33;
        case ($urandom_range(0, 2))
          0: w[31:25] = 7'h00;
          1: w[31:25] = 7'h20;
          default: w[31:25] = 7'h01;
        endcase
      end
      10: w[6:0] = ($urandom_range(0, 1) != 0) ? 7'h0F : 7'h73;
      default: w[6:0] = ($urandom_range(0, 1) != 0) ? 7'h7F : 7'h0B;
    endcase
    return w;
  endfunction

  // One clock cycle: drive, check against the model, advance the model.
  task automatic step(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                      input logic rdy, input logic fl);
    ment_t e;
    bit    byp, exp_rdy, exp_vld, push, pop;
    @(negedge clk);
    in_valid = v; in_inst = inst; in_pc = pc; out_ready = rdy; flush = fl;
    #1;
    byp     = BYP && mq.size() == 0 && mbusy == 0 && !fl && v && rdy;
    exp_rdy = (mq.size() != DEPTH) && !fl;
    exp_vld = ((mq.size() != 0) && mbusy == 0 && !fl) || byp;
    chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    chk("out_valid", 64'(out_valid), 64'(exp_vld));
    e = byp ? mdec(inst, pc) : (mq.size() != 0 ? mq[0] : mdec(32'd0, 32'd0));
    if (exp_vld) begin
      chk("out_pc", 64'(out_pc), 64'(e.pc));
      chk("out_ctrl", 64'(out_ctrl), 64'(e.ctrl));
      chk("out_imm", 64'(out_imm), 64'(e.imm));
      chk("out_rs1", 64'(out_rs1), 64'(e.rs1));
      chk("out_rs2", 64'(out_rs2), 64'(e.rs2));
      chk("out_rd", 64'(out_rd), 64'(e.rd));
      chk("out_illegal", 64'(out_illegal), 64'(e.illegal));
    end
    push = v && exp_rdy && !byp;
    pop  = exp_vld && rdy;
    if (fl) begin
      mq.delete(); mbusy = 0;
    end else begin
      if (pop && e.ctrl.muldiv && LAT > 1) mbusy = LAT - 1;
      else if (mbusy > 0) mbusy--;
      if (pop && !byp) void'(mq.pop_front());
      if (push) mq.push_back(mdec(inst, pc));
    end
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 32'd0, 32'd0, rdy, 1'b0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_ready"}, 64'(in_ready), 64'd1);
    chk({tag, "_illegal"}, 64'(out_illegal), 64'd0);
    chk({tag, "_ctrl"}, 64'(out_ctrl), 64'd0);
    chk({tag, "_pc"}, 64'(out_pc), 64'd0);
    chk({tag, "_imm"}, 64'(out_imm), 64'd0);
    chk({tag, "_regs"}, 64'({out_rs1, out_rs2, out_rd}), 64'd0);
  endtask

  initial begin
    logic [31:0] pcn;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_inst = '0; in_pc = '0; mbusy = 0;
    #2 chk_reset_outputs("rst0");
    repeat (2) @(negedge clk);
    #1 chk_reset_outputs("rst1");
    rst_n = 1'b1;

    // addi x5,x0,7
    step(1'b1, 32'h00700293, 32'h0, !BYP, 1'b0);
    idle(1'b1);
    chk("addi_valid", 64'(out_valid), 64'd1);
    chk("addi_rd", 64'(out_rd), 64'd5);
    chk("addi_imm", 64'(out_imm), 64'd7);
    chk("addi_rfm", 64'(out_ctrl.regfilemux_sel), 64'(RFM_ALU_OUT));
    chk("addi_illegal", 64'(out_illegal), 64'd0);

    // Fill to full, hold a fifth word, then drain in order; twice for wrap
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < DEPTH; i++)
        step(1'b1, 32'h00100093 + (i << 20), 32'(b * 32 + i * 4), 1'b0, 1'b0);
      step(1'b1, 32'h00900093, 32'h10, 1'b0, 1'b0);
      chk("full_ready", 64'(in_ready), 64'd0);
      step(1'b1, 32'h00900093, 32'h10, 1'b1, 1'b0);
      chk("full_pop_ready", 64'(in_ready), 64'd0);
      chk("drain_pc0", 64'(out_pc), 64'(b * 32));
      for (int i = 1; i < DEPTH; i++) begin
        idle(1'b1);
        chk("drain_pc", 64'(out_pc), 64'(b * 32 + i * 4));
      end
    end
    idle(1'b1);
    chk("drained_empty", 64'(out_valid), 64'd0);

    // mul then add: three-cycle issue gap after the mul pops
    step(1'b1, 32'h023100B3, 32'h200, 1'b0, 1'b0);
    step(1'b1, 32'h003100B3, 32'h204, 1'b0, 1'b0);
    idle(1'b1);
    chk("mul_issue", 64'({out_valid, out_ctrl.muldiv}), 64'b11);
    for (int k = 1; k < LAT; k++) begin
      idle(1'b1);
      chk("mul_gap", 64'(out_valid), 64'd0);
    end
    idle(1'b1);
    chk("add_issue_valid", 64'(out_valid), 64'd1);
    chk("add_issue_pc", 64'(out_pc), 64'h204);

    // Flush with three queued entries and a word on the input
    for (int i = 0; i < 3; i++) step(1'b1, 32'h00100093, 32'(32'h300 + i * 4), 1'b0, 1'b0);
    step(1'b1, 32'h00500093, 32'h3FC, 1'b1, 1'b1);
    idle(1'b1);
    chk("post_flush_valid", 64'(out_valid), 64'd0);
    step(1'b1, 32'h00200093, 32'h310, 1'b0, 1'b0);
    idle(1'b1);
    chk("post_flush_pc", 64'(out_pc), 64'h310);

    // sw x2,8(x1) then an unknown opcode
    step(1'b1, 32'h0020A423, 32'h400, 1'b0, 1'b0);
    step(1'b1, 32'h00000FFF, 32'h404, 1'b0, 1'b0);
    idle(1'b0);
    chk("sw_rd", 64'(out_rd), 64'd0);
    chk("sw_wmask", 64'(out_ctrl.dmem_wmask), 64'hF);
    chk("sw_imm", 64'(out_imm), 64'd8);
    idle(1'b1);
    idle(1'b1);
    chk("ill_flag", 64'(out_illegal), 64'd1);
    chk("ill_mem", 64'({out_ctrl.dmem_read, out_ctrl.dmem_write}), 64'd0);
    chk("ill_rd", 64'(out_rd), 64'd0);
    idle(1'b1);

`ifdef DECODE_BYPASS_EN
    step(1'b1, 32'h123450B7, 32'h500, 1'b1, 1'b0);
    chk("byp_valid", 64'(out_valid), 64'd1);
    chk("byp_imm", 64'(out_imm), 64'h12345000);
    idle(1'b1);
    chk("byp_empty", 64'(out_valid), 64'd0);
`endif

    // Reset in the middle of traffic drops everything
    step(1'b1, 32'h00100093, 32'h600, 1'b0, 1'b0);
    step(1'b1, 32'h00200093, 32'h604, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("rst_mid");
    mq.delete(); mbusy = 0;
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic
    pcn = 32'h1000;
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 3) != 0, rnd_inst(), pcn,
           $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0);
      pcn += 4;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
